alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       op;
    logic             inverted;
    logic             carry_in;
    logic             decimal;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             zero;
    logic             overflow;
    logic             negative;
    modport master (
        output in_valid, a_in, b_in, op, inverted, carry_in, decimal, shamt, out_ready,
        input  in_ready, out_valid, out, carry_out, zero, overflow, negative
    );
    modport slave (
        input  in_valid, a_in, b_in, op, inverted, carry_in, decimal, shamt, out_ready,
        output in_ready, out_valid, out, carry_out, zero, overflow, negative
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with binary/BCD add, logic ops and bit-serial shifts/rotates.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = (SHW > $clog2(WIDTH) ? SHW : $clog2(WIDTH)) + 1;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t st_q, st_d;
    logic rdy_q;
    logic [3:0] op_q, op_d;
    logic inv_q, inv_d, dec_q, dec_d, c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic co_q, co_d, z_q, z_d, vf_q, vf_d, n_q, n_d;
    logic [WIDTH-1:0] in_bp, in_sum, bp, sh_w, w_nx, res;
    logic [WIDTH:0] sum;
    logic [4:0] nsum;
    logic [3:0] dig;
    logic nc, sh_c, c_nx, res_c, is_sh, step, in_sh;

    assign in_bp  = bus.inverted ? ~bus.b_in : bus.b_in;
    assign in_sum = bus.a_in + in_bp + WIDTH'(bus.carry_in);
    assign in_sh  = bus.op >= 4'd5 && bus.op <= 4'd8;
    assign bp     = inv_q ? ~b_q : b_q;
    assign sum    = {1'b0, a_q} + {1'b0, bp} + (WIDTH+1)'(c_q);
    // BCD digit step on the low nibbles; a_q/b_q shift down one nibble per cycle
    assign nsum   = {1'b0, a_q[3:0]} + {1'b0, bp[3:0]} + 5'(c_q);
    assign nc     = inv_q ? nsum[4] : nsum > 5'd9;
    assign dig    = inv_q ? (nc ? nsum[3:0] : nsum[3:0] - 4'd6) : (nc ? nsum[3:0] + 4'd6 : nsum[3:0]);
    assign is_sh  = op_q >= 4'd5 && op_q <= 4'd8;
    assign step   = cnt_q != '0;
    assign sh_w   = op_q == 4'd5 ? {1'b0, w_q[WIDTH-1:1]} :
                    op_q == 4'd6 ? {c_q, w_q[WIDTH-1:1]} :
                    op_q == 4'd7 ? {w_q[WIDTH-2:0], 1'b0} : {w_q[WIDTH-2:0], c_q};
    assign sh_c   = op_q <= 4'd6 ? w_q[0] : w_q[WIDTH-1];
    assign w_nx   = dec_q ? {dig, w_q[WIDTH-1:4]} : (is_sh && step) ? sh_w : w_q;
    assign c_nx   = dec_q ? nc : (is_sh && step) ? sh_c : c_q;
    assign res    = op_q == 4'd1 ? (dec_q ? w_nx : sum[WIDTH-1:0]) :
                    op_q == 4'd2 ? a_q & b_q :
                    op_q == 4'd3 ? a_q ^ b_q :
                    op_q == 4'd4 ? a_q | b_q :
                    is_sh ? w_nx : '0;
    assign res_c  = op_q == 4'd1 ? (dec_q ? c_nx : sum[WIDTH]) : is_sh ? c_nx : 1'b0;

    always_comb begin
        st_d  = st_q;
        op_d  = op_q;
        inv_d = inv_q;
        dec_d = dec_q;
        c_d   = c_q;
        v_d   = v_q;
        a_d   = a_q;
        b_d   = b_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        out_d = out_q;
        co_d  = co_q;
        z_d   = z_q;
        vf_d  = vf_q;
        n_d   = n_q;
        if (st_q == IDLE && rdy_q && bus.in_valid) begin
            st_d  = EXEC;
            op_d  = bus.op;
            inv_d = bus.inverted;
            dec_d = bus.decimal && bus.op == 4'd1;
            c_d   = bus.carry_in;
            a_d   = bus.a_in;
            b_d   = bus.b_in;
            w_d   = bus.a_in;
            v_d   = bus.op == 4'd1 && bus.a_in[WIDTH-1] == in_bp[WIDTH-1] && in_sum[WIDTH-1] != bus.a_in[WIDTH-1];
            cnt_d = (bus.decimal && bus.op == 4'd1) ? CW'(WIDTH / 4) : in_sh ? CW'(bus.shamt) : CW'(1);
        end else if (st_q == EXEC) begin
            a_d   = dec_q ? a_q >> 4 : a_q;
            b_d   = dec_q ? b_q >> 4 : b_q;
            w_d   = w_nx;
            c_d   = c_nx;
            cnt_d = step ? cnt_q - CW'(1) : cnt_q;
            if (cnt_q <= CW'(1)) begin
                st_d  = DONE;
                out_d = res;
                co_d  = res_c;
                z_d   = res == '0;
                vf_d  = v_q;
                n_d   = res[WIDTH-1];
            end
        end else if (st_q == DONE && bus.out_ready) begin
            st_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            rdy_q <= 1'b0;
            op_q  <= '0;
            inv_q <= 1'b0;
            dec_q <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
            out_q <= '0;
            co_q  <= 1'b0;
            z_q   <= 1'b0;
            vf_q  <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            st_q  <= st_d;
            rdy_q <= 1'b1;
            op_q  <= op_d;
            inv_q <= inv_d;
            dec_q <= dec_d;
            c_q   <= c_d;
            v_q   <= v_d;
            a_q   <= a_d;
            b_q   <= b_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            co_q  <= co_d;
            z_q   <= z_d;
            vf_q  <= vf_d;
            n_q   <= n_d;
        end
    end

    assign bus.in_ready  = rdy_q && st_q == IDLE;
    assign bus.out_valid = st_q == DONE;
    assign bus.out       = out_q;
    assign bus.carry_out = co_q;
    assign bus.zero      = z_q;
    assign bus.overflow  = vf_q;
    assign bus.negative  = n_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at WIDTH=8.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic inv, input logic cin, input logic dec, input logic [2:0] sh,
                       input logic [7:0] eo, input logic ec, input logic ez, input logic ev,
                       input logic en, input int elat);
        logic [7:0] prev;
        int lat;
        @(negedge clk);
        bus.op = op; bus.a_in = a; bus.b_in = b; bus.inverted = inv;
        bus.carry_in = cin; bus.decimal = dec; bus.shamt = sh; bus.in_valid = 1'b1;
        prev = bus.out;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = ~op; bus.a_in = ~a; bus.b_in = ~b; bus.inverted = ~inv;
        bus.carry_in = ~cin; bus.decimal = ~dec; bus.shamt = ~sh;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.out_valid) chk({tag, "/hold"}, 32'(bus.out), 32'(prev));
        end while (!bus.out_valid && lat < 40);
        chk({tag, "/lat"}, lat, elat);
        chk({tag, "/rdy"}, 32'(bus.in_ready), 0);
        chk({tag, "/out"}, 32'(bus.out), 32'(eo));
        chk({tag, "/flags"}, {bus.carry_out, bus.zero, bus.overflow, bus.negative}, {ec, ez, ev, en});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "/idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] held;
        logic [3:0] hflags;
        logic seen;
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] held;
        logic [3:0] hflags;
        logic seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;
        bus.inverted = 1'b0; bus.carry_in = 1'b0; bus.decimal = 1'b0; bus.shamt = '0;
        #12;
        chk("rst/outs", {bus.out_valid, bus.in_ready, bus.out}, 10'h0);
        chk("rst/flags", {bus.carry_out, bus.zero, bus.overflow, bus.negative}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst/rdy_low", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1 chk("rst/rdy_rise", 32'(bus.in_ready), 1);

        //       tag         op   a      b      inv  cin  dec  sh  out   C Z V N lat
        run("sum50",   1, 8'h50, 8'h50, 0, 0, 0, 0, 8'hA0, 0, 0, 1, 1, 1);
        run("subFF",   1, 8'h00, 8'h01, 1, 1, 0, 0, 8'hFF, 0, 0, 0, 1, 1);
        run("sub00",   1, 8'h01, 8'h01, 1, 1, 0, 0, 8'h00, 1, 1, 0, 0, 1);
        run("dadd",    1, 8'h58, 8'h46, 0, 0, 1, 0, 8'h04, 1, 0, 1, 0, 2);
        run("dsub",    1, 8'h46, 8'h12, 1, 1, 1, 0, 8'h34, 1, 0, 0, 0, 2);
        run("dadd99",  1, 8'h99, 8'h01, 0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 2);
        run("and",     2, 8'hF0, 8'h3C, 1, 1, 1, 0, 8'h30, 0, 0, 0, 0, 1);
        run("eor",     3, 8'hFF, 8'h0F, 0, 1, 0, 5, 8'hF0, 0, 0, 0, 1, 1);
        run("or0",     4, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1);
        run("ror3",    6, 8'h01, 8'h00, 0, 1, 0, 3, 8'h60, 0, 0, 0, 0, 3);
        run("sl1",     7, 8'h81, 8'h00, 0, 0, 0, 1, 8'h02, 1, 0, 0, 0, 1);
        run("sr2",     5, 8'h81, 8'h00, 0, 0, 0, 2, 8'h20, 0, 0, 0, 0, 2);
        run("rol1",    8, 8'h80, 8'h00, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 1);
        run("ror0",    6, 8'h5A, 8'h00, 0, 1, 0, 0, 8'h5A, 1, 0, 0, 0, 1);
        run("sl7",     7, 8'h01, 8'h00, 0, 0, 0, 7, 8'h80, 0, 0, 0, 1, 7);
        run("undef0",  0, 8'hFF, 8'hFF, 0, 1, 0, 3, 8'h00, 0, 1, 0, 0, 1);
        run("undef9",  9, 8'hFF, 8'h01, 0, 1, 1, 3, 8'h00, 0, 1, 0, 0, 1);

        // backpressure: result must sit untouched while out_ready stays low
        @(negedge clk);
        bus.op = 4'd1; bus.a_in = 8'h50; bus.b_in = 8'h50; bus.inverted = 1'b0;
        bus.carry_in = 1'b0; bus.decimal = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 chk("bp/valid", 32'(bus.out_valid), 1);
        held = bus.out;
        hflags = {bus.carry_out, bus.zero, bus.overflow, bus.negative};
        chk("bp/out0", 32'(held), 32'hA0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a_in = 8'h01; bus.b_in = 8'h02;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("bp/stable", {bus.out_valid, bus.in_ready, bus.out, bus.carry_out, bus.zero, bus.overflow, bus.negative},
                {1'b1, 1'b0, held, hflags});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("bp/idle", {bus.out_valid, bus.in_ready}, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 seen |= bus.out_valid;
        end
        chk("bp/no_accept", 32'(seen), 0);

        // reset in the second EXEC cycle of a 7-step rotate
        @(negedge clk);
        bus.op = 4'd6; bus.a_in = 8'h81; bus.carry_in = 1'b1; bus.shamt = 3'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst/outs", {bus.out_valid, bus.in_ready, bus.out}, 10'h0);
        chk("mrst/flags", {bus.carry_out, bus.zero, bus.overflow, bus.negative}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mrst/rdy", 32'(bus.in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 seen |= bus.out_valid;
        end
        chk("mrst/no_valid", 32'(seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
